// File: rtl/alu_pkg.sv
// Shared ALU definitions: one-hot control bit positions, widths, requester IDs
// and the packed operation struct carried from a requester into the ALU.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 12;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic [CTRL_W-1:0] control;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
  } alu_op_t;
endpackage

// File: rtl/alu.sv
// Combinational one-hot ALU. A non-one-hot control resolves by fixed priority,
// add highest down to lui; control of all zeros yields 0.
module alu
  import alu_pkg::*;
(
  input  logic [CTRL_W-1:0] control,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] result
);
  always_comb begin
    result = '0;
    if      (control[ALU_ADD])  result = src1 + src2;
    else if (control[ALU_SUB])  result = src1 - src2;
    else if (control[ALU_SLT])  result = {{(DATA_W-1){1'b0}}, $signed(src1) < $signed(src2)};
    else if (control[ALU_SLTU]) result = {{(DATA_W-1){1'b0}}, src1 < src2};
    else if (control[ALU_AND])  result = src1 & src2;
    else if (control[ALU_NOR])  result = ~(src1 | src2);
    else if (control[ALU_OR])   result = src1 | src2;
    else if (control[ALU_XOR])  result = src1 ^ src2;
    // Shifts take the amount from src1[4:0] and shift src2.
    else if (control[ALU_SLL])  result = src2 << src1[4:0];
    else if (control[ALU_SRL])  result = src2 >> src1[4:0];
    else if (control[ALU_SRA])  result = $unsigned($signed(src2) >>> src1[4:0]);
    else if (control[ALU_LUI])  result = {src2[15:0], 16'h0000};
  end
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a one-entry result buffer.
// Define ALU_ARB_FIXED_PRI_EN for strict priority (req0 always wins ties).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_control,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_control,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);
  logic        rr;
  logic        grant;
  logic        can_accept;
  logic        accept;
  alu_op_t     op;
  logic [DATA_W-1:0] alu_result;

  assign can_accept = ~rsp_valid | rsp_ready;

  always_comb begin
    grant = REQ0;
    if (req0_valid && req1_valid) grant = rr;
    else if (req1_valid)          grant = REQ1;
  end

  assign req0_ready = can_accept & req0_valid & (grant == REQ0);
  assign req1_ready = can_accept & req1_valid & (grant == REQ1);
  assign accept     = req0_ready | req1_ready;

  // Idle ALU inputs are zeroed so the datapath does not toggle with stale requests.
  always_comb begin
    op = '0;
    if (req0_valid || req1_valid)
      op = (grant == REQ1) ? alu_op_t'{req1_control, req1_src1, req1_src2}
                           : alu_op_t'{req0_control, req0_src1, req0_src2};
  end

  alu u_alu (
    .control (op.control),
    .src1    (op.src1),
    .src2    (op.src2),
    .result  (alu_result)
  );

`ifdef ALU_ARB_FIXED_PRI_EN
  assign rr = REQ0;
`else
  always_ff @(posedge clk) begin
    if (reset)       rr <= REQ0;
    else if (accept) rr <= ~grant;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= REQ0;
      rsp_result <= '0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= grant;
      rsp_result <= alu_result;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a second CNT_W=2 instance shares the stimulus
// so counter saturation is visible within a few accepts.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [11:0] req0_control, req1_control;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [31:0] rsp_result;
  logic [15:0] grant_cnt0, grant_cnt1;
  logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id;
  logic [31:0] s_rsp_result;
  logic [1:0]  s_grant_cnt0, s_grant_cnt1;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] C_ADD = 12'h800;
  localparam logic [11:0] C_SUB = 12'h400;
  localparam logic [11:0] C_SLT = 12'h200;
  localparam logic [11:0] C_SLL = 12'h008;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_control(req0_control),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_control(req1_control),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  alu_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_control(req0_control),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_control(req1_control),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_result(s_rsp_result),
    .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    req0_control = '0; req0_src1 = '0; req0_src2 = '0;
    req1_control = '0; req1_src1 = '0; req1_src2 = '0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    do_reset();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b id=%b result=%0d, expected 0 0 0", rsp_valid, rsp_id, rsp_result);
    end
    checks++;
    if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: cnt0=%0d cnt1=%0d, expected 0 0", grant_cnt0, grant_cnt1);
    end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_control = C_ADD; req0_src1 = 5; req0_src2 = 7;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: req0_ready=%b req1_ready=%b, expected 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_id !== 1'b0 || grant_cnt0 !== 16'd1) begin
      errors++;
      $display("FAIL single_rsp: valid=%b result=%0d id=%b cnt0=%0d, expected 1 12 0 1",
               rsp_valid, rsp_result, rsp_id, grant_cnt0);
    end
    // control of zero still issues and yields 0
    req1_valid = 1; req1_control = '0; req1_src1 = 32'h55; req1_src2 = 32'h66;
    tick();
    req1_valid = 0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_id !== 1'b1 || grant_cnt1 !== 16'd1) begin
      errors++;
      $display("FAIL ctrl_zero: valid=%b result=%0d id=%b cnt1=%0d, expected 1 0 1 1",
               rsp_valid, rsp_result, rsp_id, grant_cnt1);
    end
  endtask

  task automatic test_tie();
    logic [3:0] exp_ids;
`ifdef ALU_ARB_FIXED_PRI_EN
    exp_ids = 4'b0000;
`else
    exp_ids = 4'b1010;  // bit i = id of grant i: 0,1,0,1
`endif
    do_reset();
    req0_valid = 1; req0_control = C_SUB; req0_src1 = 10; req0_src2 = 3;
    req1_valid = 1; req1_control = C_SLL; req1_src1 = 4;  req1_src2 = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req0_ready !== ~exp_ids[i] || req1_ready !== exp_ids[i]) begin
        errors++;
        $display("FAIL tie_ready[%0d]: req0_ready=%b req1_ready=%b, expected grant %b",
                 i, req0_ready, req1_ready, exp_ids[i]);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_ids[i] ||
          rsp_result !== (exp_ids[i] ? 32'd16 : 32'd7)) begin
        errors++;
        $display("FAIL tie_rsp[%0d]: valid=%b id=%b result=%0d, expected 1 %b %0d",
                 i, rsp_valid, rsp_id, rsp_result, exp_ids[i], exp_ids[i] ? 16 : 7);
      end
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req1_valid = 1; req1_control = C_SLT; req1_src1 = 32'hFFFF_FFFF; req1_src2 = 1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: req1_ready=%b, expected 1", req1_ready);
    end
    tick();
    req1_valid = 0; rsp_ready = 0;
    req0_valid = 1; req0_control = C_ADD; req0_src1 = 1; req0_src2 = 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd1 || rsp_id !== 1'b1 || req0_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall[%0d]: valid=%b result=%0d id=%b req0_ready=%b, expected 1 1 1 0",
                 i, rsp_valid, rsp_result, rsp_id, req0_ready);
      end
      tick();
    end
    rsp_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_refill_ready: req0_ready=%b, expected 1", req0_ready);
    end
    tick();
    req0_valid = 0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd3 || rsp_id !== 1'b0 || grant_cnt0 !== 16'd1) begin
      errors++;
      $display("FAIL bp_refill: valid=%b result=%0d id=%b cnt0=%0d, expected 1 3 0 1",
               rsp_valid, rsp_result, rsp_id, grant_cnt0);
    end
  endtask

  task automatic test_drain();
    // follows backpressure: result 3 from req0 pending
    rsp_ready = 1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd3 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL drain: valid=%b result=%0d id=%b, expected 0 3 0", rsp_valid, rsp_result, rsp_id);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    req0_valid = 1; req0_control = C_ADD; req0_src1 = 1; req0_src2 = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (s_grant_cnt0 !== exp_sat[i] || grant_cnt0 !== 16'(i + 1)) begin
        errors++;
        $display("FAIL sat[%0d]: cnt0_w2=%0d cnt0_w16=%0d, expected %0d %0d",
                 i, s_grant_cnt0, grant_cnt0, exp_sat[i], i + 1);
      end
    end
    req0_valid = 0;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    rsp_ready = 0;
    req1_valid = 1; req1_control = C_ADD; req1_src1 = 2; req1_src2 = 2;
    tick();
    req1_valid = 0;
    checks++;
    if (rsp_valid !== 1'b1 || grant_cnt1 !== 16'd1) begin
      errors++;
      $display("FAIL stall_setup: valid=%b cnt1=%0d, expected 1 1", rsp_valid, grant_cnt1);
    end
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (rsp_valid !== 1'b0 || grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL stall_reset: valid=%b cnt0=%0d cnt1=%0d, expected 0 0 0",
               rsp_valid, grant_cnt0, grant_cnt1);
    end
    rsp_ready = 1;
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_tie: req0_ready=%b req1_ready=%b, expected 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    reset = 1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    req0_control = '0; req0_src1 = '0; req0_src2 = '0;
    req1_control = '0; req1_src1 = '0; req1_src2 = '0;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_drain();
    test_saturation();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
